// File: rtl/race_input_hub.sv
// Shared multi-player button front end: sync, debounce and edge-detect each button,
// then track lobby readiness, lane positions and the first player to reach the finish.
module race_input_hub #(
    parameter int NUM_PLAYERS     = 4,
    parameter int MAX_POS         = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int PW = (MAX_POS > 1) ? $clog2(MAX_POS) : 1,
    localparam int IW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_PLAYERS-1:0]    btn,
    input  logic [1:0]                current_screen,
    output logic [NUM_PLAYERS*PW-1:0] cur_pos,
    output logic [NUM_PLAYERS-1:0]    ready_mask,
    output logic                      all_ready,
    output logic [NUM_PLAYERS-1:0]    activity,
    output logic                      winner_valid,
    output logic [IW-1:0]             winner_id
);
    localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] DB_LIMIT = CW'(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] LAST_POS = PW'(MAX_POS - 1);

    typedef enum logic [1:0] {
        SCR_LOBBY  = 2'b00,
        SCR_RACE   = 2'b01,
        SCR_RESULT = 2'b10,
        SCR_CLEAR  = 2'b11
    } screen_e;

    screen_e screen;
    assign screen = screen_e'(current_screen);

    logic [NUM_PLAYERS-1:0] sync1_q, sync2_q;
    logic [NUM_PLAYERS-1:0] level_q, level_d;
    logic [NUM_PLAYERS-1:0] prev_q;
    logic [NUM_PLAYERS-1:0] press;
    logic [CW-1:0]          cnt_q [NUM_PLAYERS];
    logic [CW-1:0]          cnt_d [NUM_PLAYERS];
    logic [PW-1:0]          pos_q [NUM_PLAYERS];
    logic [PW-1:0]          pos_d [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] ready_q, ready_d;
    logic                   wv_q, wv_d;
    logic [IW-1:0]          wid_q, wid_d;
    logic                   landed;

    // Debounce: the counter must run past DEBOUNCE_CYCLES mismatching samples before the level flips.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        level_d = level_q;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == DB_LIMIT) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = level_q & ~prev_q;

    always_comb begin
        pos_d   = pos_q;
        ready_d = ready_q;
        wv_d    = wv_q;
        wid_d   = wid_q;
        landed  = 1'b0;
        case (screen)
            SCR_LOBBY: begin
                if (!wv_q) ready_d = ready_q | press;
            end
            SCR_RACE: begin
                // Ascending scan so the lowest index claims a simultaneous finish.
                if (!wv_q) begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (press[i] && ready_q[i] && (pos_q[i] != LAST_POS)) begin
                            pos_d[i] = pos_q[i] + 1'b1;
                            if ((pos_d[i] == LAST_POS) && !landed) begin
                                landed = 1'b1;
                                wid_d  = IW'(i);
                            end
                        end
                    end
                    if (landed) wv_d = 1'b1;
                end
            end
            SCR_RESULT: begin
            end
            SCR_CLEAR: begin
                for (int i = 0; i < NUM_PLAYERS; i++) pos_d[i] = '0;
                ready_d = '0;
                wv_d    = 1'b0;
                wid_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // Synchroniser resets high: a button held through reset must re-qualify as a fresh 0->1.
            sync1_q <= '1;
            sync2_q <= '1;
            level_q <= '0;
            prev_q  <= '0;
            ready_q <= '0;
            wv_q    <= 1'b0;
            wid_q   <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                cnt_q[i] <= '0;
                pos_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            ready_q <= ready_d;
            wv_q    <= wv_d;
            wid_q   <= wid_d;
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
        assign cur_pos[g*PW +: PW] = pos_q[g];
    end

    assign ready_mask   = ready_q;
    assign all_ready    = &ready_q;
    assign activity     = level_q;
    assign winner_valid = wv_q;
    assign winner_id    = wid_q;

endmodule

// File: tb/tb_race_input_hub.sv
// Scoreboard bench for race_input_hub: a behavioural game model queues expected outputs
// per press, and each scenario task also checks cycle-exact latency and boundaries inline.
module tb_race_input_hub;
    localparam int NP = 4;
    localparam int MP = 16;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  btn;
    logic [1:0]  current_screen;
    logic [15:0] cur_pos;
    logic [3:0]  ready_mask;
    logic        all_ready;
    logic [3:0]  activity;
    logic        winner_valid;
    logic [1:0]  winner_id;

    race_input_hub #(
        .NUM_PLAYERS    (NP),
        .MAX_POS        (MP),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn           (btn),
        .current_screen(current_screen),
        .cur_pos       (cur_pos),
        .ready_mask    (ready_mask),
        .all_ready     (all_ready),
        .activity      (activity),
        .winner_valid  (winner_valid),
        .winner_id     (winner_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pos;
        logic [3:0]  ready;
        logic        all_rdy;
        logic        wv;
        logic [1:0]  wid;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    int         m_pos [NP];
    logic [3:0] m_ready;
    logic       m_wv;
    int         m_wid;

    function automatic void model_clear();
        for (int i = 0; i < NP; i++) m_pos[i] = 0;
        m_ready = '0;
        m_wv    = 1'b0;
        m_wid   = 0;
    endfunction

    function automatic void apply_press(input logic [3:0] mask);
        bit hit = 1'b0;
        case (current_screen)
            2'b00: if (!m_wv) m_ready = m_ready | mask;
            2'b01: begin
                if (!m_wv) begin
                    for (int i = 0; i < NP; i++) begin
                        if (mask[i] && m_ready[i] && m_pos[i] < MP - 1) begin
                            m_pos[i] = m_pos[i] + 1;
                            if (m_pos[i] == MP - 1 && !hit) begin
                                hit   = 1'b1;
                                m_wid = i;
                            end
                        end
                    end
                    if (hit) m_wv = 1'b1;
                end
            end
            2'b11: model_clear();
            default: ;
        endcase
    endfunction

    function automatic void push_expect(input string name);
        exp_t e;
        for (int i = 0; i < NP; i++) e.pos[i*4 +: 4] = m_pos[i][3:0];
        e.ready   = m_ready;
        e.all_rdy = &m_ready;
        e.wv      = m_wv;
        e.wid     = m_wid[1:0];
        exp_q.push_back(e);
        name_q.push_back(name);
    endfunction

    task automatic scoreboard_pop();
        exp_t  e;
        string nm;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (cur_pos !== e.pos) begin
                n_bad++;
                $display("FAIL %s cur_pos: got %h expected %h", nm, cur_pos, e.pos);
            end
            n_cmp++;
            if (ready_mask !== e.ready) begin
                n_bad++;
                $display("FAIL %s ready_mask: got %b expected %b", nm, ready_mask, e.ready);
            end
            n_cmp++;
            if (all_ready !== e.all_rdy) begin
                n_bad++;
                $display("FAIL %s all_ready: got %b expected %b", nm, all_ready, e.all_rdy);
            end
            n_cmp++;
            if (winner_valid !== e.wv) begin
                n_bad++;
                $display("FAIL %s winner_valid: got %b expected %b", nm, winner_valid, e.wv);
            end
            n_cmp++;
            if (winner_id !== e.wid) begin
                n_bad++;
                $display("FAIL %s winner_id: got %0d expected %0d", nm, winner_id, e.wid);
            end
        end
    endtask

    // Hold the masked buttons for `hold` sampled edges, release, let the pipeline settle, then compare.
    task automatic press(input logic [3:0] mask, input int hold, input string name);
        @(negedge clk);
        btn = btn | mask;
        repeat (hold) @(negedge clk);
        btn = btn & ~mask;
        if (hold >= DB + 1) apply_press(mask);
        push_expect(name);
        repeat (16) @(negedge clk);
        scoreboard_pop();
    endtask

    task automatic clear_screen();
        @(negedge clk);
        current_screen = 2'b11;
        @(negedge clk);
        current_screen = 2'b00;
        model_clear();
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        btn            = '0;
        current_screen = 2'b00;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (cur_pos !== 16'h0) begin n_bad++; $display("FAIL reset cur_pos: got %h expected 0", cur_pos); end
        n_cmp++;
        if (ready_mask !== 4'b0) begin n_bad++; $display("FAIL reset ready_mask: got %b expected 0", ready_mask); end
        n_cmp++;
        if (all_ready !== 1'b0) begin n_bad++; $display("FAIL reset all_ready: got %b expected 0", all_ready); end
        n_cmp++;
        if (activity !== 4'b0) begin n_bad++; $display("FAIL reset activity: got %b expected 0", activity); end
        n_cmp++;
        if (winner_valid !== 1'b0) begin n_bad++; $display("FAIL reset winner_valid: got %b expected 0", winner_valid); end
        n_cmp++;
        if (winner_id !== 2'd0) begin n_bad++; $display("FAIL reset winner_id: got %0d expected 0", winner_id); end
    endtask

    task automatic test_join();
        current_screen = 2'b00;
        @(negedge clk);
        btn = 4'b0101;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (activity !== 4'b0000) begin n_bad++; $display("FAIL join activity_early: got %b expected 0000", activity); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (activity !== 4'b0101) begin n_bad++; $display("FAIL join activity_rise: got %b expected 0101", activity); end
        n_cmp++;
        if (ready_mask !== 4'b0000) begin n_bad++; $display("FAIL join ready_early: got %b expected 0000", ready_mask); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ready_mask !== 4'b0101) begin n_bad++; $display("FAIL join ready_at_7: got %b expected 0101", ready_mask); end
        n_cmp++;
        if (all_ready !== 1'b0) begin n_bad++; $display("FAIL join all_ready_partial: got %b expected 0", all_ready); end
        repeat (12) @(negedge clk);
        btn = '0;
        apply_press(4'b0101);
        push_expect("join_0101");
        repeat (16) @(negedge clk);
        scoreboard_pop();
        press(4'b1010, 6, "join_1010");
        n_cmp++;
        if (all_ready !== 1'b1) begin n_bad++; $display("FAIL join all_ready_full: got %b expected 1", all_ready); end
    endtask

    task automatic test_lockout();
        clear_screen();
        press(4'b0001, 6, "lockout_join0");
        current_screen = 2'b01;
        for (int n = 0; n < 10; n++) press(4'b0100, 6, "lockout_p2");
        for (int n = 0; n < 10; n++) press(4'b0001, 6, "lockout_p0");
        n_cmp++;
        if (cur_pos[3:0] !== 4'd10) begin n_bad++; $display("FAIL lockout pos0: got %0d expected 10", cur_pos[3:0]); end
    endtask

    task automatic test_debounce();
        current_screen = 2'b01;
        press(4'b0001, 3, "debounce_3cyc");
        press(4'b0001, 6, "debounce_6cyc");
        press(4'b0001, 100, "debounce_hold100");
    endtask

    task automatic test_simultaneous_finish();
        clear_screen();
        press(4'b1111, 6, "finish_join");
        current_screen = 2'b01;
        for (int n = 0; n < MP - 2; n++) press(4'b1010, 6, "finish_climb");
        @(negedge clk);
        btn = 4'b1010;
        repeat (7) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (winner_valid !== 1'b0) begin n_bad++; $display("FAIL finish wv_early: got %b expected 0", winner_valid); end
        n_cmp++;
        if (cur_pos[7:4] !== 4'd14) begin n_bad++; $display("FAIL finish pos1_early: got %0d expected 14", cur_pos[7:4]); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (winner_valid !== 1'b1) begin n_bad++; $display("FAIL finish wv_edge: got %b expected 1", winner_valid); end
        n_cmp++;
        if (cur_pos[15:12] !== 4'd15) begin n_bad++; $display("FAIL finish pos3_edge: got %0d expected 15", cur_pos[15:12]); end
        btn = '0;
        apply_press(4'b1010);
        push_expect("finish_land");
        repeat (16) @(negedge clk);
        scoreboard_pop();
        press(4'b0100, 6, "finish_after_p2");
        press(4'b1111, 6, "finish_after_all");
    endtask

    task automatic test_result_clear();
        current_screen = 2'b10;
        press(4'b1111, 6, "result_frozen");
        @(negedge clk);
        current_screen = 2'b11;
        @(negedge clk);
        current_screen = 2'b10;
        model_clear();
        push_expect("clear_one_cycle");
        scoreboard_pop();
    endtask

    task automatic test_reset_mid_hold();
        clear_screen();
        press(4'b0001, 6, "midhold_join");
        current_screen = 2'b01;
        press(4'b0001, 6, "midhold_race");
        @(negedge clk);
        btn = 4'b0001;
        repeat (20) @(negedge clk);
        apply_press(4'b0001);
        push_expect("midhold_before_reset");
        scoreboard_pop();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        n_cmp++;
        if (activity !== 4'b0000) begin n_bad++; $display("FAIL midhold activity_reset: got %b expected 0000", activity); end
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (activity[0] !== 1'b0) begin n_bad++; $display("FAIL midhold activity_early: got %b expected 0", activity[0]); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (activity[0] !== 1'b1) begin n_bad++; $display("FAIL midhold activity_back: got %b expected 1", activity[0]); end
        repeat (50) @(negedge clk);
        push_expect("midhold_after_reset");
        scoreboard_pop();
        btn = '0;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_join();
        test_lockout();
        test_debounce();
        test_simultaneous_finish();
        test_result_clear();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
